token_req_queue: RTL and testbench

- Requester-side companion to token_bucket. Buffers incoming jobs in a FIFO and issues one-cycle req_o pulses to a token_bucket grant port.
- Retires the head job when the grant returns, and drops jobs that exceed a retry limit.
- Sits between a job source (valid/ready) and a rate-limited consumer, and keeps grant and drop statistics.

---
 rtl/token_pkg.sv | 29 ++
 rtl/token_req_fifo.sv | 67 ++++++
 rtl/token_req_queue.sv | 143 ++++++++++++++
 tb/tb_token_req_queue.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/token_pkg.sv
// ============================================================
// token_pkg: shared types, constants and helpers for token_req_queue
// Rev 1.0
// ============================================================
`default_nettype none

package token_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } tq_state_e;

  // Default refill settings shared with token_bucket.
  localparam int unsigned c_DEFAULT_DEN      = 16;
  localparam int unsigned c_DEFAULT_RATE_NUM = 3;

  // Increment that sticks at 2^w-1 (w up to 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [32:0] lim;
    lim = (33'd1 << w) - 33'd1;
    if ({1'b0, v} >= lim) return lim[31:0];
    else                  return v + 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/token_req_fifo.sv
// ============================================================
// token_req_fifo: job storage with pointers, occupancy count and flush
// Rev 1.0
// ============================================================
`default_nettype none

module token_req_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [DATA_W-1:0]          wr_data,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = $clog2(DEPTH+1);

  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic               w_wr;
  logic               w_rd;

  // Full is taken from the registered count only, so a same-cycle pop never frees a slot.
  assign full    = (r_count == c_CNT_W'(DEPTH));
  assign empty   = (r_count == '0);
  assign count   = r_count;
  assign rd_data = r_mem[r_rd_ptr];
  assign w_wr    = push && !full && !flush;
  assign w_rd    = pop && !empty && !flush;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/token_req_queue.sv
// ============================================================
// token_req_queue: buffers jobs and paces token requests to token_bucket
// Rev 1.0
// ============================================================
`default_nettype none

module token_req_queue #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned MAX_RETRY = 15,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [DATA_W-1:0]          in_data_i,
  input  logic                       flush_i,
  output logic                       req_o,
  input  logic                       grant_i,
  output logic                       out_valid_o,
  output logic [DATA_W-1:0]          out_data_o,
  output logic                       drop_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic [CNT_W-1:0]           grant_cnt_o,
  output logic [CNT_W-1:0]           drop_cnt_o,
  output logic                       err_o
);

  import token_pkg::*;

  localparam int c_LVL_W = $clog2(DEPTH+1);
  localparam int c_RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY+1) : 1;

  tq_state_e          r_state;
  logic [c_RTY_W-1:0] r_retry;
  logic               r_req;
  logic               r_out_valid;
  logic [DATA_W-1:0]  r_out_data;
  logic               r_drop;
  logic [CNT_W-1:0]   r_grant_cnt;
  logic [CNT_W-1:0]   r_drop_cnt;
  logic               r_err;

  logic               w_full;
  logic               w_empty;
  logic [c_LVL_W-1:0] w_level;
  logic [DATA_W-1:0]  w_head;
  logic               w_push;
  logic               w_grant_hit;
  logic               w_drop;
  logic               w_pop;
  logic               w_more;

  token_req_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (in_valid_i),
    .pop     (w_pop),
    .flush   (flush_i),
    .wr_data (in_data_i),
    .rd_data (w_head),
    .full    (w_full),
    .empty   (w_empty),
    .count   (w_level)
  );

  always_comb begin
    w_push      = in_valid_i && !w_full && !flush_i;
    w_grant_hit = (r_state == WAIT) && grant_i && !flush_i;
    w_drop      = (r_state == WAIT) && !grant_i && !flush_i && (MAX_RETRY != 0) &&
                  ((32'(r_retry) + 32'd1) == 32'(MAX_RETRY));
    w_pop       = w_grant_hit || w_drop;
    // Jobs remain after this pop if more than the head is queued or one arrives now.
    w_more      = (w_level > c_LVL_W'(1)) || w_push;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_retry     <= '0;
      r_req       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_drop      <= 1'b0;
      r_grant_cnt <= '0;
      r_drop_cnt  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_req       <= 1'b0;
      r_out_valid <= 1'b0;
      r_drop      <= 1'b0;
      if (grant_i && (r_state != WAIT)) r_err <= 1'b1;
      if (flush_i) begin
        r_state <= IDLE;
        r_retry <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (!w_empty) begin
              r_state <= REQ;
              r_req   <= 1'b1;
            end
          end
          REQ: r_state <= WAIT;
          WAIT: begin
            if (w_grant_hit || w_drop) begin
              if (w_grant_hit) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_head;
                r_grant_cnt <= CNT_W'(sat_inc(32'(r_grant_cnt), CNT_W));
              end else begin
                r_drop     <= 1'b1;
                r_drop_cnt <= CNT_W'(sat_inc(32'(r_drop_cnt), CNT_W));
              end
              r_retry <= '0;
              r_state <= w_more ? REQ : IDLE;
              r_req   <= w_more;
            end else begin
              r_retry <= r_retry + c_RTY_W'(1);
              r_state <= REQ;
              r_req   <= 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign in_ready_o  = !w_full;
  assign req_o       = r_req;
  assign out_valid_o = r_out_valid;
  assign out_data_o  = r_out_data;
  assign drop_o      = r_drop;
  assign level_o     = w_level;
  assign grant_cnt_o = r_grant_cnt;
  assign drop_cnt_o  = r_drop_cnt;
  assign err_o       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_token_req_queue.sv
// ============================================================
// tb_token_req_queue: directed self-checking bench for token_req_queue
// Rev 1.0
// ============================================================
`default_nettype none

module tb_token_req_queue;

  localparam int DW = 32;
  localparam int CW = 16;
  localparam int LW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          a_in_valid = 1'b0, a_in_ready, a_flush = 1'b0, a_req, a_grant;
  logic          a_out_valid, a_drop, a_err;
  logic [DW-1:0] a_in_data = '0, a_out_data;
  logic [LW-1:0] a_level;
  logic [CW-1:0] a_gcnt, a_dcnt;

  logic          b_in_valid = 1'b0, b_in_ready, b_req;
  logic          b_out_valid, b_drop, b_err;
  logic [DW-1:0] b_in_data = '0, b_out_data;
  logic [LW-1:0] b_level;
  logic [CW-1:0] b_gcnt, b_dcnt;

  token_req_queue #(.DATA_W(DW), .DEPTH(8), .MAX_RETRY(15), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid_i(a_in_valid), .in_ready_o(a_in_ready),
    .in_data_i(a_in_data), .flush_i(a_flush), .req_o(a_req), .grant_i(a_grant),
    .out_valid_o(a_out_valid), .out_data_o(a_out_data), .drop_o(a_drop),
    .level_o(a_level), .grant_cnt_o(a_gcnt), .drop_cnt_o(a_dcnt), .err_o(a_err)
  );

  token_req_queue #(.DATA_W(DW), .DEPTH(8), .MAX_RETRY(3), .CNT_W(CW)) dut_drop (
    .clk(clk), .rst(rst), .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
    .in_data_i(b_in_data), .flush_i(1'b0), .req_o(b_req), .grant_i(1'b0),
    .out_valid_o(b_out_valid), .out_data_o(b_out_data), .drop_o(b_drop),
    .level_o(b_level), .grant_cnt_o(b_gcnt), .drop_cnt_o(b_dcnt), .err_o(b_err)
  );

  // Grant source: 0 = silent, 1 = bucket always full, 2 = 3/16 refill, burst 8.
  int   gmode  = 0;
  int   tokens = 0;
  int   acc    = 0;
  logic model_grant = 1'b0;
  logic man_grant   = 1'b0;
  assign a_grant = model_grant | man_grant;

  always @(posedge clk) begin
    if (gmode == 2) begin
      acc = acc + 3;
      if (acc >= 16) begin
        acc = acc - 16;
        if (tokens < 8) tokens = tokens + 1;
      end
    end
    if (rst) model_grant <= 1'b0;
    else if (a_req && gmode == 1) model_grant <= 1'b1;
    else if (a_req && gmode == 2 && tokens > 0) begin
      model_grant <= 1'b1;
      tokens = tokens - 1;
    end else model_grant <= 1'b0;
  end

  int n_tests = 0;
  int n_fail  = 0;

  int            mon_n;
  int            mon_cyc [20];
  logic [DW-1:0] mon_dat [20];
  int            push_idx;

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({a_in_ready, a_req, a_out_valid, a_drop, a_err} !== 5'b10000) begin
      n_fail++; $display("FAIL reset_flags got %b exp 10000", {a_in_ready, a_req, a_out_valid, a_drop, a_err});
    end
    n_tests++;
    if ({a_level, a_gcnt, a_dcnt} !== '0) begin
      n_fail++; $display("FAIL reset_counts got lvl=%0d g=%0d d=%0d exp 0", a_level, a_gcnt, a_dcnt);
    end
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({b_in_ready, b_req, b_drop, b_level, b_dcnt, a_out_data} !== {1'b1, 2'b00, 4'd0, 16'd0, 32'd0}) begin
      n_fail++; $display("FAIL reset_release got rdy=%b req=%b lvl=%0d data=%0h exp rdy=1 others 0", b_in_ready, b_req, b_level, a_out_data);
    end
  endtask

  task automatic test_single();
    int req_cyc, gr_cyc, ov_cyc;
    logic [DW-1:0] od;
    req_cyc = -1; gr_cyc = -1; ov_cyc = -1; od = '0;
    gmode = 1;
    @(posedge clk); #1;
    a_in_valid = 1'b1; a_in_data = 32'hA5;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (a_req && req_cyc < 0) req_cyc = c;
      if (a_grant && gr_cyc < 0) gr_cyc = c;
      if (a_out_valid && ov_cyc < 0) begin ov_cyc = c; od = a_out_data; end
    end
    n_tests++;
    if (req_cyc != 2) begin n_fail++; $display("FAIL single_req_cycle got %0d exp 2", req_cyc); end
    n_tests++;
    if (gr_cyc != 3) begin n_fail++; $display("FAIL single_grant_cycle got %0d exp 3", gr_cyc); end
    n_tests++;
    if (ov_cyc != 4) begin n_fail++; $display("FAIL single_release_cycle got %0d exp 4", ov_cyc); end
    n_tests++;
    if (od !== 32'hA5) begin n_fail++; $display("FAIL single_data got %0h exp a5", od); end
    n_tests++;
    if (a_gcnt !== 16'd1) begin n_fail++; $display("FAIL single_grant_cnt got %0d exp 1", a_gcnt); end
  endtask

  task automatic test_burst();
    gmode = 1;
    mon_n = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          @(posedge clk); #1;
          a_in_valid = 1'b1; a_in_data = 32'h100 + i;
        end
        @(posedge clk); #1;
        a_in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 60; c++) begin
          @(negedge clk);
          if (a_out_valid) begin
            if (mon_n < 20) begin mon_dat[mon_n] = a_out_data; mon_cyc[mon_n] = c; end
            mon_n++;
          end
        end
      end
    join
    n_tests++;
    if (mon_n != 8) begin n_fail++; $display("FAIL burst_count got %0d exp 8", mon_n); end
    for (int k = 0; k < 8; k++) begin
      n_tests++;
      if (k >= mon_n || mon_dat[k] !== 32'h100 + k) begin
        n_fail++; $display("FAIL burst_order[%0d] got %0h exp %0h", k, (k < mon_n) ? mon_dat[k] : 32'hX, 32'h100 + k);
      end
    end
    for (int k = 1; k < 8; k++) begin
      n_tests++;
      if (k >= mon_n || mon_cyc[k] - mon_cyc[k-1] != 2) begin
        n_fail++; $display("FAIL burst_spacing[%0d] got %0d exp 2", k, (k < mon_n) ? mon_cyc[k] - mon_cyc[k-1] : -1);
      end
    end
    n_tests++;
    if (a_gcnt !== 16'd9 || a_dcnt !== 16'd0) begin
      n_fail++; $display("FAIL burst_counters got g=%0d d=%0d exp g=9 d=0", a_gcnt, a_dcnt);
    end
  endtask

  task automatic test_bucket();
    int span;
    @(posedge clk); #1;
    tokens = 8; acc = 0; gmode = 2;
    mon_n = 0; push_idx = 0;
    fork
      begin
        for (int k = 0; k < 200 && push_idx < 20; k++) begin
          @(posedge clk); #1;
          a_in_valid = 1'b1; a_in_data = 32'h300 + push_idx;
          @(negedge clk);
          if (a_in_ready) push_idx++;
        end
        @(posedge clk); #1;
        a_in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 300; c++) begin
          @(negedge clk);
          if (a_out_valid) begin
            if (mon_n < 20) begin mon_dat[mon_n] = a_out_data; mon_cyc[mon_n] = c; end
            mon_n++;
          end
        end
      end
    join
    gmode = 0;
    n_tests++;
    if (mon_n != 20) begin n_fail++; $display("FAIL bucket_count got %0d exp 20", mon_n); end
    for (int k = 0; k < 20; k++) begin
      n_tests++;
      if (k >= mon_n || mon_dat[k] !== 32'h300 + k) begin
        n_fail++; $display("FAIL bucket_order[%0d] got %0h exp %0h", k, (k < mon_n) ? mon_dat[k] : 32'hX, 32'h300 + k);
      end
    end
    // Six releases at 3 tokens per 16 cycles take about 32 cycles.
    span = (mon_n >= 20) ? mon_cyc[19] - mon_cyc[13] : -1;
    n_tests++;
    if (span < 27 || span > 39) begin n_fail++; $display("FAIL bucket_rate got span %0d exp 27..39", span); end
    n_tests++;
    if (a_gcnt !== 16'd29 || a_dcnt !== 16'd0) begin
      n_fail++; $display("FAIL bucket_counters got g=%0d d=%0d exp g=29 d=0", a_gcnt, a_dcnt);
    end
  endtask

  task automatic test_drop();
    int reqs, nd, nov;
    int dc [2];
    reqs = 0; nd = 0; nov = 0; dc[0] = -1; dc[1] = -1;
    @(posedge clk); #1;
    b_in_valid = 1'b1; b_in_data = 32'h1;
    @(posedge clk); #1;
    b_in_data = 32'h2;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    for (int c = 2; c <= 30; c++) begin
      @(negedge clk);
      if (b_req) reqs++;
      if (b_out_valid) nov++;
      if (b_drop) begin
        if (nd < 2) dc[nd] = c;
        nd++;
      end
    end
    n_tests++;
    if (reqs != 6) begin n_fail++; $display("FAIL drop_req_count got %0d exp 6", reqs); end
    n_tests++;
    if (nd != 2 || dc[0] != 8 || dc[1] != 14) begin
      n_fail++; $display("FAIL drop_pulses got n=%0d at %0d,%0d exp n=2 at 8,14", nd, dc[0], dc[1]);
    end
    n_tests++;
    if (b_dcnt !== 16'd2 || b_level !== 4'd0 || nov != 0 || b_gcnt !== 16'd0) begin
      n_fail++; $display("FAIL drop_final got d=%0d lvl=%0d ov=%0d g=%0d exp d=2 lvl=0 ov=0 g=0", b_dcnt, b_level, nov, b_gcnt);
    end
  endtask

  task automatic test_full();
    gmode = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      a_in_valid = 1'b1; a_in_data = 32'h200 + i;
    end
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (a_in_ready !== 1'b0 || a_level !== 4'd8) begin
      n_fail++; $display("FAIL full_level got rdy=%b lvl=%0d exp rdy=0 lvl=8", a_in_ready, a_level);
    end
    @(posedge clk); #1;
    a_in_valid = 1'b1; a_in_data = 32'hDEAD;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (a_in_ready !== 1'b0 || a_level !== 4'd8) begin
      n_fail++; $display("FAIL full_reject got rdy=%b lvl=%0d exp rdy=0 lvl=8", a_in_ready, a_level);
    end
  endtask

  task automatic test_flush();
    logic [CW-1:0] g0, d0;
    bit found;
    int bad;
    g0 = a_gcnt; d0 = a_dcnt; found = 0; bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (a_req) begin found = 1; break; end
    end
    n_tests++;
    if (!found) begin n_fail++; $display("FAIL flush_find_req got none exp req within 20 cycles"); end
    @(posedge clk); #1;
    a_flush = 1'b1; man_grant = 1'b1;
    @(posedge clk); #1;
    a_flush = 1'b0; man_grant = 1'b0;
    @(negedge clk);
    n_tests++;
    if (a_level !== 4'd0 || a_in_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_level got lvl=%0d rdy=%b exp lvl=0 rdy=1", a_level, a_in_ready);
    end
    for (int c = 0; c < 6; c++) begin
      if (a_out_valid || a_drop || a_req) bad++;
      @(negedge clk);
    end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL flush_quiet got %0d active cycles exp 0", bad); end
    n_tests++;
    if (a_gcnt !== g0 || a_dcnt !== d0 || a_err !== 1'b0) begin
      n_fail++; $display("FAIL flush_counters got g=%0d d=%0d err=%b exp g=%0d d=%0d err=0", a_gcnt, a_dcnt, a_err, g0, d0);
    end
  endtask

  task automatic test_spurious();
    @(posedge clk); #1;
    man_grant = 1'b1;
    @(posedge clk); #1;
    man_grant = 1'b0;
    @(negedge clk);
    n_tests++;
    if (a_err !== 1'b1 || a_out_valid !== 1'b0 || a_level !== 4'd0) begin
      n_fail++; $display("FAIL spurious_err got err=%b ov=%b lvl=%0d exp err=1 ov=0 lvl=0", a_err, a_out_valid, a_level);
    end
    repeat (5) @(negedge clk);
    n_tests++;
    if (a_err !== 1'b1) begin n_fail++; $display("FAIL spurious_sticky got %b exp 1", a_err); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (a_err !== 1'b0 || a_gcnt !== 16'd0) begin
      n_fail++; $display("FAIL spurious_rst_clear got err=%b g=%0d exp err=0 g=0", a_err, a_gcnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_bucket();
    test_drop();
    test_full();
    test_flush();
    test_spurious();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
